// File: rtl/timer_device_if.sv
// Device-side bus of the countdown timer: word select, byte-enabled write, read data and IRQ.
// Handshake: no valid/ready; a write is presented with We=1 for one cycle and takes effect at the next rising edge.
interface timer_device_if;
    logic [1:0]  Addr;
    logic        We;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output Addr, We, BE, WD, input RD, IRQ);
    modport slave  (input Addr, We, BE, WD, output RD, IRQ);
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a masked IRQ.
// Optional TIMER_ACK_EN: Addr 3 reads irq_flag and a write of 1 there acknowledges it.
module timer_device #(
    parameter int unsigned DIV          = 1,
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        irq_q, irq_d;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_mode;

    always_comb begin
        wr_ctrl   = bus.We && (bus.Addr == 2'd0);
        wr_preset = bus.We && (bus.Addr == 2'd1);
        auto_mode = (ctrl_q[2:1] == 2'b01);

        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        presc_d  = presc_q;
        irq_d    = irq_q;

`ifdef TIMER_ACK_EN
        // Applied first so an INT-state set in the same cycle wins.
        if (bus.We && (bus.Addr == 2'd3) && bus.BE[0] && bus.WD[0])
            irq_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0])
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Ends the single-cycle auto-reload pulse; a one-shot flag was already cleared by the enabling write.
                count_d = preset_q;
                presc_d = 16'd0;
                irq_d   = 1'b0;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = ST_INT;
                end else if (presc_q == DIV_LAST) begin
                    count_d = count_q - 32'd1;
                    presc_d = 16'd0;
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            ST_INT: begin
                irq_d = 1'b1;
                if (auto_mode) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software writes come last so they override the FSM's EN clear and flag set.
        if (wr_ctrl) begin
            if (bus.BE[0])
                ctrl_d = bus.WD[3:0];
            irq_d = 1'b0;
        end
        if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.BE[i])
                    preset_d[i*8 +: 8] = bus.WD[i*8 +: 8];
            end
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= RESET_PRESET;
            count_q  <= 32'h0;
            presc_q  <= 16'h0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        case (bus.Addr)
            2'd0:    bus.RD = {28'h0, ctrl_q};
            2'd1:    bus.RD = preset_q;
            2'd2:    bus.RD = count_q;
`ifdef TIMER_ACK_EN
            default: bus.RD = {31'h0, irq_q};
`else
            default: bus.RD = 32'h0;
`endif
        endcase
    end

    assign bus.IRQ   = irq_q & ctrl_q[3];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: one DIV=1 and one DIV=4 instance checked against an arithmetic timing model.
// Inputs change on the falling edge; outputs are sampled on the falling edge (or 1ns after an address change).
module tb_timer_device;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timer_device_if bus1();
  timer_device_if bus4();
  logic [1:0] st1, st4;

  timer_device #(.DIV(1)) u_t1 (.clk(clk), .reset(reset), .bus(bus1), .dbg_state(st1));
  timer_device #(.DIV(4)) u_t4 (.clk(clk), .reset(reset), .bus(bus4), .dbg_state(st4));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] d;

  // ---------------- reference model ----------------
  // Enable write is edge k=0: LOAD at k=1, COUNT=P after k=2, one decrement per d cycles,
  // zero check, INT, so the flag appears after edge P*d+4; auto-reload repeats every P*d+3.
  function automatic logic exp_irq(input int k, input int p, input int dv, input bit auto_m);
    int t0;
    t0 = p * dv + 4;
    if (k < t0) return 1'b0;
    if (!auto_m) return 1'b1;
    return ((k - t0) % (p * dv + 3)) == 0;
  endfunction

  function automatic logic [31:0] exp_count(input int k, input int p, input int dv);
    int dec;
    if (k < 2) return 32'h0;
    dec = (k - 2) / dv;
    if (dec >= p) return 32'h0;
    return 32'(p - dec);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic we, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (which == 0) begin
      bus1.We = we; bus1.Addr = a; bus1.BE = be; bus1.WD = wd;
    end else begin
      bus4.We = we; bus4.Addr = a; bus4.BE = be; bus4.WD = wd;
    end
  endtask

  // Called at a falling edge; the write is captured at the following rising edge.
  task automatic wr(input int which, input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd);
    drive(which, 1'b1, a, be, wd);
    @(negedge clk);
    drive(which, 1'b0, 2'd2, 4'h0, 32'h0);
  endtask

  task automatic rd(input int which, input logic [1:0] a, output logic [31:0] data);
    if (which == 0) bus1.Addr = a; else bus4.Addr = a;
    #1;
    data = (which == 0) ? bus1.RD : bus4.RD;
    if (which == 0) bus1.Addr = 2'd2; else bus4.Addr = 2'd2;
  endtask

  function automatic logic irq_of(input int which);
    return (which == 0) ? bus1.IRQ : bus4.IRQ;
  endfunction

  task automatic do_reset();
    drive(0, 1'b0, 2'd2, 4'h0, 32'h0);
    drive(1, 1'b0, 2'd2, 4'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %0h expected 0", d); end
    rd(0, 2'd1, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_preset: got %0h expected 0", d); end
    rd(0, 2'd2, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_count: got %0h expected 0", d); end
    rd(0, 2'd3, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_addr3: got %0h expected 0", d); end
    n_vec++; if (irq_of(0) !== 1'b0 || irq_of(1) !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b/%b expected 0/0", irq_of(0), irq_of(1)); end
    n_vec++; if (st1 !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", st1); end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd100);
    wr(0, 2'd0, 4'hF, 32'h9);
    repeat (20) @(negedge clk);
    rd(0, 2'd2, d);
    n_vec++; if (d !== exp_count(20, 100, 1)) begin
      n_err++; $display("FAIL midcount_count: got %0d expected %0d", d, exp_count(20, 100, 1)); end
    reset = 1'b1;
    #1;
    rd(0, 2'd2, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midreset_count: got %0d expected 0", d); end
    n_vec++; if (st1 !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %0d expected 0", st1); end
    n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b expected 0", irq_of(0)); end
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midreset_ctrl: got %0h expected 0", d); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL postreset_irq: got %b expected 0", irq_of(0)); end
  endtask

  task automatic test_one_shot();
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd5);
    wr(0, 2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      rd(0, 2'd2, d);
      n_vec++; if (d !== exp_count(k, 5, 1)) begin
        n_err++; $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, d, exp_count(k, 5, 1)); end
      n_vec++; if (irq_of(0) !== exp_irq(k, 5, 1, 1'b0)) begin
        n_err++; $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq_of(0), exp_irq(k, 5, 1, 1'b0)); end
    end
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl: got %0h expected 8", d); end
    wr(0, 2'd1, 4'hF, 32'd3);
    n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL oneshot_preset_clear: got %b expected 0", irq_of(0)); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd2);
    wr(0, 2'd0, 4'hF, 32'h9);
    repeat (5) @(negedge clk);
    // This write lands on the INT-state edge.
    wr(0, 2'd0, 4'hF, 32'h9);
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'h9) begin n_err++; $display("FAIL simul_ctrl: got %0h expected 9", d); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL simul_irq c=%0d: got %b expected 0", k, irq_of(0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_auto_reload();
    int seen, want;
    seen = 0; want = 0;
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd3);
    wr(0, 2'd0, 4'hF, 32'hB);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_vec++; if (irq_of(0) !== exp_irq(k, 3, 1, 1'b1)) begin
        n_err++; $display("FAIL auto_irq k=%0d: got %b expected %b", k, irq_of(0), exp_irq(k, 3, 1, 1'b1)); end
      if (irq_of(0) === 1'b1) seen++;
      if (exp_irq(k, 3, 1, 1'b1)) want++;
    end
    n_vec++; if (seen !== want) begin n_err++; $display("FAIL auto_pulses: got %0d expected %0d", seen, want); end
  endtask

  task automatic test_byte_enables();
    do_reset();
    wr(0, 2'd0, 4'b0001, 32'hFFFF_FFFF);
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'hF) begin n_err++; $display("FAIL be_ctrl: got %0h expected f", d); end
    // MODE 11 behaves as one-shot; PRESET is still 0.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_vec++; if (irq_of(0) !== exp_irq(k, 0, 1, 1'b0)) begin
        n_err++; $display("FAIL mode3_irq k=%0d: got %b expected %b", k, irq_of(0), exp_irq(k, 0, 1, 1'b0)); end
    end
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'hE) begin n_err++; $display("FAIL mode3_ctrl: got %0h expected e", d); end
    wr(0, 2'd1, 4'b0011, 32'hAB00_0002);
    rd(0, 2'd1, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL be_preset: got %0h expected 2", d); end
    wr(0, 2'd0, 4'hF, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rd(0, 2'd2, d);
      n_vec++; if (d !== exp_count(k, 2, 1)) begin
        n_err++; $display("FAIL masked_count k=%0d: got %0d expected %0d", k, d, exp_count(k, 2, 1)); end
      n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL masked_irq k=%0d: got %b expected 0", k, irq_of(0)); end
    end
`ifdef TIMER_ACK_EN
    rd(0, 2'd3, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL masked_flag: got %0h expected 1", d); end
`endif
  endtask

  task automatic test_boundary();
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd0);
    wr(0, 2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++; if (irq_of(0) !== exp_irq(k, 0, 1, 1'b0)) begin
        n_err++; $display("FAIL preset0_irq k=%0d: got %b expected %b", k, irq_of(0), exp_irq(k, 0, 1, 1'b0)); end
    end
    wr(0, 2'd2, 4'hF, 32'h1234);
    rd(0, 2'd2, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL count_write: got %0h expected 0", d); end
    // PRESET rewritten mid-count must not disturb the running COUNT.
    wr(0, 2'd1, 4'hF, 32'd6);
    wr(0, 2'd0, 4'hF, 32'h9);
    repeat (3) @(negedge clk);
    wr(0, 2'd1, 4'hF, 32'd1);
    for (int k = 4; k <= 12; k++) begin
      rd(0, 2'd2, d);
      n_vec++; if (d !== exp_count(k, 6, 1)) begin
        n_err++; $display("FAIL preset_midcnt k=%0d: got %0d expected %0d", k, d, exp_count(k, 6, 1)); end
      n_vec++; if (irq_of(0) !== exp_irq(k, 6, 1, 1'b0)) begin
        n_err++; $display("FAIL preset_midcnt_irq k=%0d: got %b expected %b", k, irq_of(0), exp_irq(k, 6, 1, 1'b0)); end
      @(negedge clk);
    end
    do_reset();
    wr(1, 2'd1, 4'hF, 32'd3);
    wr(1, 2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rd(1, 2'd2, d);
      n_vec++; if (d !== exp_count(k, 3, 4)) begin
        n_err++; $display("FAIL div4_count k=%0d: got %0d expected %0d", k, d, exp_count(k, 3, 4)); end
      n_vec++; if (irq_of(1) !== exp_irq(k, 3, 4, 1'b0)) begin
        n_err++; $display("FAIL div4_irq k=%0d: got %b expected %b", k, irq_of(1), exp_irq(k, 3, 4, 1'b0)); end
    end
  endtask

  task automatic test_random();
    int which, dv, p, n;
    bit am;
    for (int t = 0; t < 8; t++) begin
      which = $urandom_range(0, 1);
      dv = (which == 0) ? 1 : 4;
      p = $urandom_range(0, 10);
      am = 1'($urandom_range(0, 1));
      n = 2 * (p * dv + 3) + 6;
      do_reset();
      wr(which, 2'd1, 4'hF, 32'(p));
      wr(which, 2'd0, 4'hF, am ? 32'hB : 32'h9);
      exp_q.delete();
      for (int k = 1; k <= n; k++) exp_q.push_back(exp_count(k, p, dv));
      for (int k = 1; k <= n; k++) begin
        logic [31:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++; if (irq_of(which) !== exp_irq(k, p, dv, am)) begin
          n_err++; $display("FAIL rand_irq t=%0d k=%0d p=%0d div=%0d auto=%0d: got %b expected %b",
                            t, k, p, dv, am, irq_of(which), exp_irq(k, p, dv, am)); end
        if (!am) begin
          rd(which, 2'd2, d);
          n_vec++; if (d !== e) begin
            n_err++; $display("FAIL rand_count t=%0d k=%0d: got %0d expected %0d", t, k, d, e); end
        end
      end
    end
  endtask

  task automatic test_ack();
    do_reset();
    wr(0, 2'd1, 4'hF, 32'd1);
    wr(0, 2'd0, 4'hF, 32'h9);
    repeat (6) @(negedge clk);
    n_vec++; if (irq_of(0) !== 1'b1) begin n_err++; $display("FAIL ack_fired: got %b expected 1", irq_of(0)); end
`ifdef TIMER_ACK_EN
    rd(0, 2'd3, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL ack_read: got %0h expected 1", d); end
    wr(0, 2'd3, 4'b1110, 32'hFFFF_FFFF);
    n_vec++; if (irq_of(0) !== 1'b1) begin n_err++; $display("FAIL ack_be0_off: got %b expected 1", irq_of(0)); end
    wr(0, 2'd3, 4'b0001, 32'h1);
    n_vec++; if (irq_of(0) !== 1'b0) begin n_err++; $display("FAIL ack_clear: got %b expected 0", irq_of(0)); end
    rd(0, 2'd3, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ack_read_after: got %0h expected 0", d); end
`else
    rd(0, 2'd3, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL noack_read: got %0h expected 0", d); end
    wr(0, 2'd3, 4'hF, 32'hFFFF_FFFF);
    n_vec++; if (irq_of(0) !== 1'b1) begin n_err++; $display("FAIL noack_write: got %b expected 1", irq_of(0)); end
`endif
    rd(0, 2'd0, d);
    n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL ack_ctrl: got %0h expected 8", d); end
    rd(0, 2'd1, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL ack_preset: got %0h expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_one_shot();
    test_simultaneous();
    test_auto_reload();
    test_byte_enables();
    test_boundary();
    test_random();
    test_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
